irrigation_sequencer: RTL
=========================

IRRIGATION_SEQUENCER -- requirements
Module: irrigation_sequencer

Interface
REQ-001 SHALL have parameter NZ, 4, number of irrigation zones.
REQ-002 SHALL have parameter PRIME_CYC, 2, pump-prime cycles before a valve opens.
REQ-003 SHALL have parameter ACK_TO, 3, maximum cycles from St to timer-running acknowledge.
REQ-004 SHALL have port Ck, input, 1, the single clock; all state updates on the rising edge.
REQ-005 SHALL have port Clr, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port Dry, input, NZ, per-zone soil-dry request, level.
REQ-007 SHALL have port Man, input, 1, manual request to irrigate all zones.
REQ-008 SHALL have port Rain, input, 1, rain inhibit, level.
REQ-009 SHALL have port TmrR, input, 1, running flag returned by the downstream timer control unit.
REQ-010 SHALL have port St, output, 1, one-cycle start pulse to the timer control unit.
REQ-011 SHALL have port Zone, output, 2, index of the zone being served.
REQ-012 SHALL have port Valve, output, NZ, one-hot valve drive.
REQ-013 SHALL have port Pump, output, 1, pump drive.
REQ-014 SHALL have port Busy, output, 1, high when the sequencer is in any state other than IDLE or FAULT.
REQ-015 SHALL have port Fault, output, 1, sticky timer-acknowledge failure.

Function
REQ-016 SHALL be a Moore FSM with states IDLE, SCAN, PRIME, START, WAIT_ACK, RUN, CLOSE, ABORT and FAULT; all outputs SHALL be decoded from registered state and registers.
REQ-017 IDLE: with Rain=0 and (Dry!=0 or Man=1), SHALL latch pend = Dry | (Man ? all-ones : 0) and go to SCAN; with Rain=1, SHALL stay in IDLE.
REQ-018 SCAN: with pend=0, SHALL go to IDLE; otherwise SHALL register Zone = lowest set index of pend and go to PRIME.
REQ-019 PRIME: SHALL hold Pump=1 and Valve=0 for exactly PRIME_CYC cycles, then go to START.
REQ-020 START: SHALL drive St=1 for exactly one cycle with Valve[Zone]=1, then go to WAIT_ACK.
REQ-021 WAIT_ACK: TmrR=1 within ACK_TO cycles SHALL go to RUN; otherwise the state SHALL go to FAULT.
REQ-022 RUN: SHALL drive Valve[Zone]=1 and Pump=1; TmrR=0 SHALL go to CLOSE.
REQ-023 CLOSE, one cycle: SHALL drive Valve=0 and Pump=1, clear pend[Zone], and go to SCAN.
REQ-024 Rain=1 in PRIME, START, WAIT_ACK or RUN SHALL clear pend and go to ABORT.
REQ-025 ABORT: SHALL drive Valve=0 and Pump=0 and stay until TmrR=0, then go to IDLE.
REQ-026 Rain and a RUN exit on the same cycle SHALL resolve to ABORT.
REQ-027 FAULT: SHALL drive Fault=1 and all other outputs 0, and hold until Clr.
REQ-028 Valve SHALL never have more than one bit set; Valve!=0 SHALL imply Pump=1.
REQ-029 Dry and Man changes outside IDLE SHALL be ignored, with pend frozen except for clears.
REQ-030 Pump SHALL be 1 in PRIME, START, WAIT_ACK, RUN and CLOSE, and in SCAN when entered from CLOSE with pend!=0; Pump SHALL be 0 in every other state.
REQ-031 The PRIME/ACK counter SHALL be ceil(log2(max(PRIME_CYC, ACK_TO)+1)) bits, reloaded on each state entry, and SHALL never wrap.

Reset
REQ-032 Clr=1 at a Ck edge SHALL, from any state including mid-RUN, force state IDLE, pend=0, counter=0, and St, Zone, Valve, Pump, Busy and Fault all 0 on the next cycle.
REQ-033 Clr SHALL take priority over every other input.

Structure
REQ-034 Package irrig_pkg SHALL hold the state enum, NZ, PRIME_CYC and ACK_TO defaults, and the Zone width constant.
REQ-035 The cycle counter SHALL be one sub-module, cyc_cnt, with ports load, value and zero.
REQ-036 The lowest-set-bit selection SHALL be a function inside irrig_pkg.

Verification
REQ-037 Dry=0010 pulse in IDLE, TmrR rising 1 cycle after St and falling 6 cycles later -> Zone=1; St is high in the 4th cycle after leaving IDLE; Valve=0010 through RUN; back to IDLE with Pump=0.
REQ-038 Man=1 and Dry=0001 on the same cycle -> zones 0,1,2,3 served in order; exactly 4 St pulses; Pump is not dropped between zones.
REQ-039 St issued and TmrR held 0 -> Fault=1 ACK_TO+1 cycles after St; all other outputs 0; remains set until Clr.
REQ-040 Rain=1 mid-RUN while TmrR=1 -> Valve=0 and Pump=0 next cycle; ABORT holds until TmrR=0, then IDLE; pend=0.
REQ-041 Clr pulse during RUN of zone 2 -> every output 0 next cycle; no further St until a fresh Dry request.
REQ-042 Dry=1111 with Rain=1 in IDLE -> no state change; Rain drops with Dry still 1111 -> SCAN next cycle.

Source files
------------

// File: rtl/irrigation_sequencer_pkg.sv
// Shared types and defaults for the irrigation sequencer: FSM state encoding,
// zone sizing and the lowest-pending-zone picker.
package irrig_pkg;

  localparam int NZ_DEF        = 4;
  localparam int PRIME_CYC_DEF = 2;
  localparam int ACK_TO_DEF    = 3;
  localparam int ZW            = 2;
  localparam int MAX_NZ        = 1 << ZW;

  typedef enum logic [3:0] {
    IDLE,
    SCAN,
    PRIME,
    START,
    WAIT_ACK,
    RUN,
    CLOSE,
    ABORT,
    FAULT
  } state_t;

  // Lowest set index wins, so zones are always served in ascending order.
  function automatic logic [ZW-1:0] lowest_idx(input logic [MAX_NZ-1:0] v);
    logic [ZW-1:0] idx;
    idx = '0;
    for (int i = MAX_NZ - 1; i >= 0; i--)
      if (v[i]) idx = ZW'(i);
    return idx;
  endfunction

endpackage

// File: rtl/irrigation_sequencer_cyc_cnt.sv
// Down-counter for prime and ack-timeout windows; reloads on load and
// parks at zero instead of wrapping.
module cyc_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)            cnt <= '0;
    else if (load)      cnt <= value;
    else if (cnt != '0) cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/irrigation_sequencer.sv
// Zone irrigation sequencer: latches dry/manual requests, primes the pump,
// then opens each pending valve in turn under the downstream timer's control.
module irrigation_sequencer
  import irrig_pkg::*;
#(
  parameter int NZ        = NZ_DEF,
  parameter int PRIME_CYC = PRIME_CYC_DEF,
  parameter int ACK_TO    = ACK_TO_DEF
) (
  input  logic          Ck,
  input  logic          Clr,
  input  logic [NZ-1:0] Dry,
  input  logic          Man,
  input  logic          Rain,
  input  logic          TmrR,
  output logic          St,
  output logic [ZW-1:0] Zone,
  output logic [NZ-1:0] Valve,
  output logic          Pump,
  output logic          Busy,
  output logic          Fault
);

  localparam int CMAX = (PRIME_CYC > ACK_TO) ? PRIME_CYC : ACK_TO;
  localparam int CW   = $clog2(CMAX + 1);

  state_t        state;
  logic [NZ-1:0] pend;
  logic [ZW-1:0] zone_q;
  logic          pump_hold;
  logic [NZ-1:0] zone_bit;
  logic [NZ-1:0] pend_left;
  logic          ld_prime, ld_ack, cnt_load, cnt_zero;
  logic [CW-1:0] cnt_value;

  assign zone_bit  = NZ'(1) << zone_q;
  assign pend_left = pend & ~zone_bit;

  // Counter reloads on the edge that enters PRIME or WAIT_ACK.
  always_comb begin
    ld_prime  = (state == SCAN) && (pend != '0);
    ld_ack    = (state == START) && !Rain;
    cnt_load  = ld_prime || ld_ack;
    cnt_value = ld_prime ? CW'(PRIME_CYC - 1) : CW'(ACK_TO - 1);
  end

  cyc_cnt #(.W(CW)) u_cnt (
    .clk   (Ck),
    .rst   (Clr),
    .load  (cnt_load),
    .value (cnt_value),
    .zero  (cnt_zero)
  );

  always_ff @(posedge Ck) begin
    if (Clr) begin
      state     <= IDLE;
      pend      <= '0;
      zone_q    <= '0;
      pump_hold <= 1'b0;
    end else begin
      pump_hold <= 1'b0;
      case (state)
        IDLE:
          if (!Rain && (Dry != '0 || Man)) begin
            pend  <= Dry | {NZ{Man}};
            state <= SCAN;
          end
        SCAN:
          if (pend == '0) state <= IDLE;
          else begin
            zone_q <= lowest_idx(MAX_NZ'(pend));
            state  <= PRIME;
          end
        PRIME:
          if (Rain) begin
            pend  <= '0;
            state <= ABORT;
          end else if (cnt_zero) state <= START;
        START:
          if (Rain) begin
            pend  <= '0;
            state <= ABORT;
          end else state <= WAIT_ACK;
        WAIT_ACK:
          if (Rain) begin
            pend  <= '0;
            state <= ABORT;
          end else if (TmrR)    state <= RUN;
          else if (cnt_zero)    state <= FAULT;
        // Rain is tested first so a simultaneous timer drop still aborts.
        RUN:
          if (Rain) begin
            pend  <= '0;
            state <= ABORT;
          end else if (!TmrR) state <= CLOSE;
        CLOSE: begin
          pend      <= pend_left;
          pump_hold <= (pend_left != '0);
          state     <= SCAN;
        end
        ABORT:
          if (!TmrR) state <= IDLE;
        FAULT: ;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    St    = (state == START);
    Valve = (state == START || state == RUN) ? zone_bit : '0;
    Fault = (state == FAULT);
    Busy  = (state != IDLE) && (state != FAULT);
    Zone  = (state == IDLE || state == SCAN || state == FAULT) ? '0 : zone_q;
    case (state)
      PRIME, START, WAIT_ACK, RUN, CLOSE: Pump = 1'b1;
      SCAN:                               Pump = pump_hold;
      default:                            Pump = 1'b0;
    endcase
  end

endmodule
